prf_rat_mw: RTL and testbench
=============================

Name: prf_rat_mw

Overview:
- Multi-wide successor to the single-allocation rename physical register file. It holds PRF data, the speculative map table, a committed (architectural) map table, the free list and the pending list for one register class (prf_type).
- It supports NUM_ALLOC renames per cycle, NUM_COMMIT retirements per cycle, and flush recovery driven by a walk state machine.
- It sits between decode/rename (RN), register read (RD) and retire (RB).

Parameters:
- NUM_ENTRIES, 64, physical registers; must be at least RV_NUM_REGS + NUM_ALLOC.
- NUM_ALLOC, 2, rename allocations per cycle.
- NUM_COMMIT, 2, commit ports per cycle.
- NUM_REG_READS, 4, PRF data read ports.
- NUM_REG_WRITES, 2, PRF write ports.
- NUM_MAP_READS, 4, speculative map read ports.
- RECOVER_PER_CYC, 8, GPRs restored per recovery cycle; must divide RV_NUM_REGS.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- prf_type  in  t_prf_type  register class owned by this instance
- wr_en_nq_ro0  in  [NUM_REG_WRITES] x 1  write enables
- wr_pkt_ro0  in  [NUM_REG_WRITES] x t_prf_wr_pkt  write pdst and data
- rd_en_nq_rd0  in  [NUM_REG_READS] x 1  read enables
- rd_psrc_rd0  in  [NUM_REG_READS] x t_prf_id  read address
- rd_data_rd1  out  [NUM_REG_READS] x t_rv_reg_data  read data
- rdmap_nq_rd0  in  [NUM_MAP_READS] x 1  map read enables
- rdmap_gpr_rd0  in  [NUM_MAP_READS] x t_gpr_id  map read GPR
- rdmap_psrc_rd1  out  [NUM_MAP_READS] x t_prf_id  mapped psrc
- rdmap_pend_rd1  out  [NUM_MAP_READS] x 1  psrc not yet written
- alloc_pdst_rn0  in  [NUM_ALLOC] x 1  allocation requests, in program order
- gpr_id_rn0  in  [NUM_ALLOC] x t_gpr_id  destination GPRs
- rename_ready_rn0  out  1  all NUM_ALLOC allocations can be granted this cycle
- pdst_rn1  out  [NUM_ALLOC] x t_prf_id  allocated pdst
- pdst_old_rn1  out  [NUM_ALLOC] x t_prf_id  previous mapping of the GPR
- commit_en_rb1  in  [NUM_COMMIT] x 1  commit valid
- commit_gpr_rb1  in  [NUM_COMMIT] x t_gpr_id  committed GPR
- commit_pdst_rb1  in  [NUM_COMMIT] x t_prf_id  committed pdst
- flush_rbx  in  1  pipeline flush; start recovery
- recovering  out  1  recovery walk active

Behaviour:
- Reset (async assert, sync deassert):
  - Both map tables are identity (gpr g -> entry g).
  - Free list has entries RV_NUM_REGS..NUM_ENTRIES-1 set.
  - Pending list is 0 and PRF data is 0.
  - FSM is IDLE.
  - All rd1/rn1 outputs are 0; recovering = 0.
- Ports: writes, commits and allocations whose ptype differs from prf_type are ignored.
- Allocation:
  - rename_ready_rn0 = IDLE & popcount(free_list) >= NUM_ALLOC.
  - Requesters must assert alloc only when ready; an alloc without ready is a protocol error (asserted).
  - Active port k takes the k-th lowest free entry, counting only active ports.
  - Granted entries leave the free list and enter the pending list next cycle; pdst is registered to rn1 (latency 1).
  - Intra-group: pdst_old for port j is the pdst of the youngest earlier active port with the same GPR, else MAP[gpr].
  - If several ports target one GPR, the youngest wins the map.
- Writes: clear the pending bit and update data. Write-pending clear and alloc-set on the same entry in one cycle cannot occur (asserted).
- Map read: 1-cycle latency. Pending is sampled from next-state pending, so a same-cycle write reads as not pending.
- Data read: 1-cycle latency from registered array.
- Commit:
  - ARCH_MAP[gpr] <= pdst.
  - The prior ARCH_MAP[gpr] returns to the free list next cycle.
  - Multiple same-cycle commits to one GPR chain: the higher port wins; each older mapping is freed.
  - Freed entries are not allocatable in the same cycle.
- Recovery FSM, IDLE -> RECOVER on flush_rbx:
  - Next cycle: free_list <= all 1, pending <= 0, walk counter <= 0.
  - Each RECOVER cycle copies RECOVER_PER_CYC ARCH_MAP entries into MAP and clears their free bits.
  - Exits to IDLE after RV_NUM_REGS/RECOVER_PER_CYC cycles (4 with defaults).
  - recovering is high in RECOVER; allocation is blocked.
  - flush_rbx during RECOVER restarts the walk at 0.
  - Commit and flush in the same cycle: the commit is applied to ARCH_MAP first.
  - Commit during RECOVER is a protocol error (asserted).
  - PRF writes during RECOVER update data but do not set pending.
  - reset_n low mid-walk returns to reset state immediately.

Optional Feature:
- PRF_WR_BYPASS_EN:
  - When defined, a same-cycle matching write (highest write port wins) bypasses into rd_data_rd1, so a read returns the data being written.
  - When undefined, reads return the pre-write array contents (old value).

Test Plan:
- Reset release, NUM_ENTRIES=64, alloc ports 0,1 for GPR 5 and GPR 6 -> pdst_rn1 = {32, 33}; pdst_old_rn1 = {5, 6}; map read GPR 5 next cycle -> psrc 32, pend 1.
- Alloc ports 0,1 both for GPR 7 -> pdst {32, 33}; pdst_old {7, 32}; MAP[7] = 33.
- Write pdst 32 data 0xABCD, same-cycle map read of GPR 5 -> pend 0; data read of 32 next cycle -> 0xABCD with bypass, 0 without.
- Commit GPR 5 -> pdst 32 -> entry 5 free next cycle. Allocate until free count = 1 -> rename_ready_rn0 = 0.
- Three allocs, commit of one, then flush -> recovering high for exactly 4 cycles; MAP equals ARCH_MAP; free count = 64 - 32; pending all 0.
- Flush on recovery cycle 2 -> walk restarts; recovering high 4 more cycles. reset_n pulsed mid-walk -> identity maps and IDLE.

Source files
------------

// File: rtl/prf_rat_mw_if.sv
// prf_rat_mw shared types and the RN/RD/RB bus interface for the
// multi-wide rename register file.
package prf_rat_mw_pkg;
  localparam int unsigned RV_NUM_REGS     = 32;
  localparam int unsigned NUM_ENTRIES     = 64;
  localparam int unsigned NUM_ALLOC       = 2;
  localparam int unsigned NUM_COMMIT      = 2;
  localparam int unsigned NUM_REG_READS   = 4;
  localparam int unsigned NUM_REG_WRITES  = 2;
  localparam int unsigned NUM_MAP_READS   = 4;
  localparam int unsigned RECOVER_PER_CYC = 8;
  localparam int unsigned PRF_ID_W        = $clog2(NUM_ENTRIES);
  localparam int unsigned GPR_ID_W        = $clog2(RV_NUM_REGS);
  localparam int unsigned DATA_W          = 32;

  typedef enum logic {PRF_INT = 1'b0, PRF_FP = 1'b1} t_prf_type;
  typedef logic [PRF_ID_W-1:0] t_prf_id;
  typedef logic [GPR_ID_W-1:0] t_gpr_id;
  typedef logic [DATA_W-1:0]   t_rv_reg_data;

  typedef struct packed {
    t_prf_type    ptype;
    t_prf_id      pdst;
    t_rv_reg_data data;
  } t_prf_wr_pkt;
endpackage

interface prf_rat_mw_if;
  import prf_rat_mw_pkg::*;

  logic         [NUM_REG_WRITES-1:0] wr_en_nq_ro0;
  t_prf_wr_pkt  [NUM_REG_WRITES-1:0] wr_pkt_ro0;
  logic         [NUM_REG_READS-1:0]  rd_en_nq_rd0;
  t_prf_id      [NUM_REG_READS-1:0]  rd_psrc_rd0;
  t_rv_reg_data [NUM_REG_READS-1:0]  rd_data_rd1;
  logic         [NUM_MAP_READS-1:0]  rdmap_nq_rd0;
  t_gpr_id      [NUM_MAP_READS-1:0]  rdmap_gpr_rd0;
  t_prf_id      [NUM_MAP_READS-1:0]  rdmap_psrc_rd1;
  logic         [NUM_MAP_READS-1:0]  rdmap_pend_rd1;
  logic         [NUM_ALLOC-1:0]      alloc_pdst_rn0;
  t_gpr_id      [NUM_ALLOC-1:0]      gpr_id_rn0;
  logic                              rename_ready_rn0;
  t_prf_id      [NUM_ALLOC-1:0]      pdst_rn1;
  t_prf_id      [NUM_ALLOC-1:0]      pdst_old_rn1;
  logic         [NUM_COMMIT-1:0]     commit_en_rb1;
  t_gpr_id      [NUM_COMMIT-1:0]     commit_gpr_rb1;
  t_prf_id      [NUM_COMMIT-1:0]     commit_pdst_rb1;
  logic                              flush_rbx;
  logic                              recovering;

  modport master (
    output wr_en_nq_ro0, wr_pkt_ro0, rd_en_nq_rd0, rd_psrc_rd0,
           rdmap_nq_rd0, rdmap_gpr_rd0, alloc_pdst_rn0, gpr_id_rn0,
           commit_en_rb1, commit_gpr_rb1, commit_pdst_rb1, flush_rbx,
    input  rd_data_rd1, rdmap_psrc_rd1, rdmap_pend_rd1, rename_ready_rn0,
           pdst_rn1, pdst_old_rn1, recovering
  );

  modport slave (
    input  wr_en_nq_ro0, wr_pkt_ro0, rd_en_nq_rd0, rd_psrc_rd0,
           rdmap_nq_rd0, rdmap_gpr_rd0, alloc_pdst_rn0, gpr_id_rn0,
           commit_en_rb1, commit_gpr_rb1, commit_pdst_rb1, flush_rbx,
    output rd_data_rd1, rdmap_psrc_rd1, rdmap_pend_rd1, rename_ready_rn0,
           pdst_rn1, pdst_old_rn1, recovering
  );
endinterface

// File: rtl/prf_rat_mw.sv
// prf_rat_mw: multi-wide rename PRF with speculative/committed maps, free
// and pending lists, and a walk-based flush recovery.
// Optional: define PRF_WR_BYPASS_EN to forward same-cycle writes to reads.
module prf_rat_mw
  import prf_rat_mw_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  t_prf_type   prf_type,
  prf_rat_mw_if.slave bus
);
  localparam int unsigned WALK_CYCLES = RV_NUM_REGS / RECOVER_PER_CYC;
  localparam int unsigned WALK_W      = (WALK_CYCLES > 1) ? $clog2(WALK_CYCLES) : 1;
  localparam int unsigned CNT_W       = PRF_ID_W + 1;
  localparam logic [NUM_ENTRIES-1:0] FREE_RST =
    {{(NUM_ENTRIES-RV_NUM_REGS){1'b1}}, {RV_NUM_REGS{1'b0}}};

  typedef enum logic {S_IDLE, S_RECOVER} t_state;

  t_state                 state, state_nxt;
  logic [WALK_W-1:0]      walk, walk_nxt;
  t_rv_reg_data           prf_data [NUM_ENTRIES];
  t_prf_id                map      [RV_NUM_REGS];
  t_prf_id                map_nxt  [RV_NUM_REGS];
  t_prf_id                arch_map [RV_NUM_REGS];
  t_prf_id                arch_nxt [RV_NUM_REGS];
  logic [NUM_ENTRIES-1:0] free_list, free_nxt, free_ret, pending, pending_nxt;
  logic [NUM_ENTRIES-1:0] avail, alloc_mask, wr_clr;
  logic [CNT_W-1:0]       free_cnt;
  logic                   rename_ready, found;
  logic [NUM_ALLOC-1:0]   alloc_act;
  t_prf_id                alloc_pdst [NUM_ALLOC];
  t_prf_id                alloc_old  [NUM_ALLOC];
  logic [NUM_REG_WRITES-1:0] wr_act;
  t_rv_reg_data           rd_val [NUM_REG_READS];
  t_gpr_id                gidx;

  t_rv_reg_data [NUM_REG_READS-1:0] rd_data_q;
  t_prf_id      [NUM_MAP_READS-1:0] rdmap_psrc_q;
  logic         [NUM_MAP_READS-1:0] rdmap_pend_q;
  t_prf_id      [NUM_ALLOC-1:0]     pdst_q, pdst_old_q;

  // Free-entry population count gating the rename group.
  always_comb begin
    free_cnt = '0;
    for (int e = 0; e < int'(NUM_ENTRIES); e++) free_cnt = free_cnt + CNT_W'(free_list[e]);
  end

  assign rename_ready = (state == S_IDLE) && (free_cnt >= CNT_W'(NUM_ALLOC));

  // Active port k takes the k-th lowest free entry.
  always_comb begin
    avail      = free_list;
    alloc_mask = '0;
    found      = 1'b0;
    for (int k = 0; k < int'(NUM_ALLOC); k++) begin
      alloc_act[k]  = bus.alloc_pdst_rn0[k] & rename_ready;
      alloc_pdst[k] = '0;
      found         = 1'b0;
      if (alloc_act[k]) begin
        for (int e = 0; e < int'(NUM_ENTRIES); e++) begin
          if (!found && avail[e]) begin
            alloc_pdst[k] = PRF_ID_W'(e);
            found         = 1'b1;
          end
        end
        avail[alloc_pdst[k]]      = 1'b0;
        alloc_mask[alloc_pdst[k]] = 1'b1;
      end
    end
  end

  // Previous mapping, forwarded from the youngest earlier same-GPR port.
  always_comb begin
    for (int j = 0; j < int'(NUM_ALLOC); j++) begin
      alloc_old[j] = map[bus.gpr_id_rn0[j]];
      for (int i = 0; i < j; i++) begin
        if (alloc_act[i] && (bus.gpr_id_rn0[i] == bus.gpr_id_rn0[j])) alloc_old[j] = alloc_pdst[i];
      end
    end
  end

  // Writes owned by this register class and the pending bits they clear.
  always_comb begin
    wr_clr = '0;
    for (int w = 0; w < int'(NUM_REG_WRITES); w++) begin
      wr_act[w] = bus.wr_en_nq_ro0[w] && (bus.wr_pkt_ro0[w].ptype == prf_type);
      if (wr_act[w]) wr_clr[bus.wr_pkt_ro0[w].pdst] = 1'b1;
    end
  end

  // Data read mux, optionally forwarding the highest matching write port.
  always_comb begin
    for (int r = 0; r < int'(NUM_REG_READS); r++) begin
      rd_val[r] = prf_data[bus.rd_psrc_rd0[r]];
`ifdef PRF_WR_BYPASS_EN
      for (int w = 0; w < int'(NUM_REG_WRITES); w++) begin
        if (wr_act[w] && (bus.wr_pkt_ro0[w].pdst == bus.rd_psrc_rd0[r])) rd_val[r] = bus.wr_pkt_ro0[w].data;
      end
`endif
    end
  end

  // FSM next state plus map, free and pending list updates.
  always_comb begin
    state_nxt   = state;
    walk_nxt    = walk;
    map_nxt     = map;
    arch_nxt    = arch_map;
    free_nxt    = free_list;
    pending_nxt = pending & ~wr_clr;
    free_ret    = '0;
    gidx        = '0;
    for (int c = 0; c < int'(NUM_COMMIT); c++) begin
      if (bus.commit_en_rb1[c]) begin
        free_ret[arch_nxt[bus.commit_gpr_rb1[c]]] = 1'b1;
        arch_nxt[bus.commit_gpr_rb1[c]]           = bus.commit_pdst_rb1[c];
      end
    end
    case (state)
      S_IDLE: begin
        for (int k = 0; k < int'(NUM_ALLOC); k++) begin
          if (alloc_act[k]) map_nxt[bus.gpr_id_rn0[k]] = alloc_pdst[k];
        end
        free_nxt    = (free_list & ~alloc_mask) | free_ret;
        pending_nxt = (pending & ~wr_clr) | alloc_mask;
      end
      S_RECOVER: begin
        for (int r = 0; r < int'(RECOVER_PER_CYC); r++) begin
          gidx                     = GPR_ID_W'(int'(walk) * int'(RECOVER_PER_CYC) + r);
          map_nxt[gidx]            = arch_map[gidx];
          free_nxt[arch_map[gidx]] = 1'b0;
        end
        walk_nxt = walk + WALK_W'(1);
        if (walk == WALK_W'(WALK_CYCLES - 1)) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (bus.flush_rbx) begin
      state_nxt   = S_RECOVER;
      walk_nxt    = '0;
      free_nxt    = '1;
      pending_nxt = '0;
    end
  end

  // State, map tables and list registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      walk      <= '0;
      free_list <= FREE_RST;
      pending   <= '0;
      for (int g = 0; g < int'(RV_NUM_REGS); g++) begin
        map[g]      <= PRF_ID_W'(g);
        arch_map[g] <= PRF_ID_W'(g);
      end
    end else begin
      state     <= state_nxt;
      walk      <= walk_nxt;
      free_list <= free_nxt;
      pending   <= pending_nxt;
      map       <= map_nxt;
      arch_map  <= arch_nxt;
    end
  end

  // PRF data array; a higher write port overrides a lower one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int e = 0; e < int'(NUM_ENTRIES); e++) prf_data[e] <= '0;
    end else begin
      for (int w = 0; w < int'(NUM_REG_WRITES); w++) begin
        if (wr_act[w]) prf_data[bus.wr_pkt_ro0[w].pdst] <= bus.wr_pkt_ro0[w].data;
      end
    end
  end

  // Registered rd1/rn1 outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_q    <= '0;
      rdmap_psrc_q <= '0;
      rdmap_pend_q <= '0;
      pdst_q       <= '0;
      pdst_old_q   <= '0;
    end else begin
      for (int r = 0; r < int'(NUM_REG_READS); r++) begin
        if (bus.rd_en_nq_rd0[r]) rd_data_q[r] <= rd_val[r];
      end
      for (int m = 0; m < int'(NUM_MAP_READS); m++) begin
        if (bus.rdmap_nq_rd0[m]) begin
          rdmap_psrc_q[m] <= map[bus.rdmap_gpr_rd0[m]];
          rdmap_pend_q[m] <= pending_nxt[map[bus.rdmap_gpr_rd0[m]]];
        end
      end
      for (int k = 0; k < int'(NUM_ALLOC); k++) begin
        pdst_q[k]     <= alloc_pdst[k];
        pdst_old_q[k] <= alloc_old[k];
      end
    end
  end

  assign bus.rd_data_rd1      = rd_data_q;
  assign bus.rdmap_psrc_rd1   = rdmap_psrc_q;
  assign bus.rdmap_pend_rd1   = rdmap_pend_q;
  assign bus.pdst_rn1         = pdst_q;
  assign bus.pdst_old_rn1     = pdst_old_q;
  assign bus.rename_ready_rn0 = rename_ready;
  assign bus.recovering       = (state == S_RECOVER);

  // Protocol checks on the requesters.
  alloc_needs_ready: assert property (@(posedge clk) disable iff (!reset_n)
    (bus.alloc_pdst_rn0 == '0) || rename_ready);
  no_wr_alloc_clash: assert property (@(posedge clk) disable iff (!reset_n)
    (wr_clr & alloc_mask) == '0);
  no_commit_in_recover: assert property (@(posedge clk) disable iff (!reset_n)
    !((state == S_RECOVER) && (bus.commit_en_rb1 != '0)));
endmodule

// File: tb/tb_prf_rat_mw.sv
// Scoreboard bench for prf_rat_mw: stimulus pushes expectations tagged with
// the cycle they are due; a negedge monitor pops and compares them.
module tb_prf_rat_mw;
  import prf_rat_mw_pkg::*;

  logic      clk = 1'b0;
  logic      reset_n = 1'b0;
  t_prf_type prf_type = PRF_INT;
  int        cyc = 0;
  int        checks = 0;
  int        errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  prf_rat_mw_if bus ();
  prf_rat_mw dut (.clk(clk), .reset_n(reset_n), .prf_type(prf_type), .bus(bus));

  typedef enum int {K_PDST, K_OLD, K_PSRC, K_PEND, K_RDATA, K_READY, K_RECOV} kind_t;
  typedef struct {
    int          due;
    kind_t       kind;
    int          idx;
    logic [63:0] val;
    string       name;
  } exp_t;
  exp_t sb[$];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] actual(kind_t k, int i);
    case (k)
      K_PDST:  return 64'(bus.pdst_rn1[i]);
      K_OLD:   return 64'(bus.pdst_old_rn1[i]);
      K_PSRC:  return 64'(bus.rdmap_psrc_rd1[i]);
      K_PEND:  return 64'(bus.rdmap_pend_rd1[i]);
      K_RDATA: return 64'(bus.rd_data_rd1[i]);
      K_READY: return 64'(bus.rename_ready_rn0);
      K_RECOV: return 64'(bus.recovering);
      default: return '0;
    endcase
  endfunction

  // Monitor: compare every expectation due this cycle, away from posedge.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) begin
        if (sb[i].due < cyc) check({sb[i].name, "_stale"}, 64'(sb[i].due), 64'(cyc));
        else check(sb[i].name, actual(sb[i].kind, sb[i].idx), sb[i].val);
        sb.delete(i);
      end
    end
  end

  task automatic expect_at(int dly, kind_t k, int idx, logic [63:0] v, string name);
    exp_t e;
    e.due = cyc + dly; e.kind = k; e.idx = idx; e.val = v; e.name = name;
    sb.push_back(e);
  endtask

  task automatic idle_inputs();
    bus.wr_en_nq_ro0    = '0;
    bus.wr_pkt_ro0      = '0;
    bus.rd_en_nq_rd0    = '0;
    bus.rd_psrc_rd0     = '0;
    bus.rdmap_nq_rd0    = '0;
    bus.rdmap_gpr_rd0   = '0;
    bus.alloc_pdst_rn0  = '0;
    bus.gpr_id_rn0      = '0;
    bus.commit_en_rb1   = '0;
    bus.commit_gpr_rb1  = '0;
    bus.commit_pdst_rb1 = '0;
    bus.flush_rbx       = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic do_alloc(int k, int g, int epdst, int eold, string name);
    bus.alloc_pdst_rn0[k] = 1'b1;
    bus.gpr_id_rn0[k]     = t_gpr_id'(g);
    expect_at(1, K_PDST, k, 64'(epdst), {name, "_pdst"});
    if (eold >= 0) expect_at(1, K_OLD, k, 64'(eold), {name, "_old"});
  endtask

  task automatic do_mapread(int p, int g, int epsrc, int epend, string name);
    bus.rdmap_nq_rd0[p]  = 1'b1;
    bus.rdmap_gpr_rd0[p] = t_gpr_id'(g);
    expect_at(1, K_PSRC, p, 64'(epsrc), {name, "_psrc"});
    expect_at(1, K_PEND, p, 64'(epend), {name, "_pend"});
  endtask

  task automatic do_read(int p, int psrc, logic [31:0] edata, string name);
    bus.rd_en_nq_rd0[p] = 1'b1;
    bus.rd_psrc_rd0[p]  = t_prf_id'(psrc);
    expect_at(1, K_RDATA, p, 64'(edata), name);
  endtask

  task automatic do_write(int w, t_prf_type pt, int pdst, logic [31:0] d);
    bus.wr_en_nq_ro0[w]     = 1'b1;
    bus.wr_pkt_ro0[w].ptype = pt;
    bus.wr_pkt_ro0[w].pdst  = t_prf_id'(pdst);
    bus.wr_pkt_ro0[w].data  = d;
  endtask

  task automatic do_commit(int c, int g, int pdst);
    bus.commit_en_rb1[c]   = 1'b1;
    bus.commit_gpr_rb1[c]  = t_gpr_id'(g);
    bus.commit_pdst_rb1[c] = t_prf_id'(pdst);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Reset state.
    expect_at(0, K_RECOV, 0, 0, "rst_recov");
    expect_at(0, K_READY, 0, 1, "rst_ready");
    expect_at(0, K_PDST, 0, 0, "rst_pdst0");
    expect_at(0, K_OLD, 1, 0, "rst_old1");
    expect_at(0, K_PSRC, 0, 0, "rst_psrc0");
    expect_at(0, K_RDATA, 0, 0, "rst_rdata0");
    check("rst_free", 64'(dut.free_list), 64'hFFFF_FFFF_0000_0000);
    check("rst_pending", 64'(dut.pending), 64'h0);
    step();

    // Two-wide rename of distinct GPRs.
    do_alloc(0, 5, 32, 5, "a_g5");
    do_alloc(1, 6, 33, 6, "a_g6");
    step();
    do_mapread(0, 5, 32, 1, "a_map5");
    do_mapread(1, 6, 33, 1, "a_map6");
    step();

    // Write clears pending in the same cycle; wrong-class write ignored.
    do_write(0, PRF_INT, 32, 32'hABCD);
    do_write(1, PRF_FP, 33, 32'h1111);
    do_mapread(0, 5, 32, 0, "a_map5_wr");
`ifdef PRF_WR_BYPASS_EN
    do_read(0, 32, 32'hABCD, "a_rd32_same");
`else
    do_read(0, 32, 32'h0, "a_rd32_same");
`endif
    step();
    do_read(0, 32, 32'hABCD, "a_rd32_next");
    do_read(1, 33, 32'h0, "a_rd33_fp_ignored");
    do_mapread(1, 6, 33, 1, "a_map6_still_pend");
    do_commit(0, 5, 32);
    step();

    // Committed-away entry 5 is free and becomes the lowest allocatable.
    check("a_free5", 64'(dut.free_list[5]), 64'h1);
    do_alloc(0, 1, 5, 1, "a_g1");
    do_alloc(1, 2, 34, 2, "a_g2");
    step();
    for (int i = 0; i < 14; i++) begin
      do_alloc(0, i + 10, 35 + 2 * i, -1, "a_fill0");
      do_alloc(1, i + 11, 36 + 2 * i, -1, "a_fill1");
      step();
    end
    expect_at(0, K_READY, 0, 0, "a_ready_low");
    check("a_free_cnt", 64'($countones(dut.free_list)), 64'd1);
    check("a_last_free", 64'(dut.free_list[63]), 64'h1);
    step();

    // Same-GPR group: youngest wins the map, older pdst forwarded.
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    do_alloc(0, 7, 32, 7, "b_g7a");
    do_alloc(1, 7, 33, 32, "b_g7b");
    step();
    do_mapread(0, 7, 33, 1, "b_map7");
    step();

    // Three allocs, a commit, then flush with the commit in the same cycle.
    do_alloc(0, 3, 34, 3, "c_g3");
    do_alloc(1, 4, 35, 4, "c_g4");
    step();
    do_alloc(0, 8, 36, 8, "c_g8");
    step();
    do_commit(0, 7, 33);
    bus.flush_rbx = 1'b1;
    expect_at(0, K_RECOV, 0, 0, "c_recov_pre");
    step();
    for (int i = 0; i < 4; i++) begin
      expect_at(0, K_RECOV, 0, 1, "c_recov_hi");
      if (i == 0) expect_at(0, K_READY, 0, 0, "c_ready_blocked");
      step();
    end
    expect_at(0, K_RECOV, 0, 0, "c_recov_done");
    expect_at(0, K_READY, 0, 1, "c_ready_back");
    check("c_free_cnt", 64'($countones(dut.free_list)), 64'd32);
    check("c_pending", 64'(dut.pending), 64'h0);
    for (int b = 0; b < 8; b++) begin
      for (int p = 0; p < 4; p++) begin
        do_mapread(p, 4 * b + p, (4 * b + p == 7) ? 33 : 4 * b + p, 0, "c_map");
      end
      step();
    end
    do_alloc(0, 9, 7, 9, "c_post_g9");
    do_alloc(1, 10, 32, 10, "c_post_g10");
    step();

    // Flush on recovery cycle 2 restarts the walk.
    bus.flush_rbx = 1'b1;
    expect_at(0, K_RECOV, 0, 0, "d_recov_pre");
    step();
    expect_at(0, K_RECOV, 0, 1, "d_recov_c1");
    step();
    expect_at(0, K_RECOV, 0, 1, "d_recov_c2");
    bus.flush_rbx = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      expect_at(0, K_RECOV, 0, 1, "d_recov_restart");
      step();
    end
    expect_at(0, K_RECOV, 0, 0, "d_recov_done");
    do_mapread(0, 7, 33, 0, "d_map7");
    do_mapread(1, 9, 9, 0, "d_map9");
    step();

    // Reset mid-walk returns to identity maps and IDLE at once.
    bus.flush_rbx = 1'b1;
    step();
    step();
    reset_n = 1'b0;
    #1;
    check("e_async_recov", 64'(bus.recovering), 64'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    expect_at(0, K_RECOV, 0, 0, "e_recov");
    expect_at(0, K_READY, 0, 1, "e_ready");
    do_mapread(0, 7, 7, 0, "e_map7");
    step();
    do_alloc(0, 1, 32, 1, "e_g1");
    do_alloc(1, 2, 33, 2, "e_g2");
    step();
    step();
    step();

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
